// File: rtl/obi_result_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : obi_result_mailbox
// Purpose  : OBI data-bus slave collecting 128-bit AES encryption/decryption
//            results from four word writes each, with status, clear and a
//            sticky program-done flag. Always ready; one registered response
//            per grant.
// Revision : 1.0 - initial release
// ============================================================================
module obi_result_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         data_req_i,
    output logic         data_gnt_o,
    input  logic [31:0]  data_addr_i,
    input  logic         data_we_i,
    input  logic [3:0]   data_be_i,
    input  logic [31:0]  data_wdata_i,
    output logic         data_rvalid_o,
    output logic [31:0]  data_rdata_o,
    output logic         data_err_o,
    output logic [127:0] result_enc_o,
    output logic [127:0] result_dec_o,
    output logic         enc_valid_o,
    output logic         dec_valid_o,
    output logic         program_done_o
);

    localparam logic [3:0] C_OFF_STATUS = 4'd8;
    localparam logic [3:0] C_OFF_CLEAR  = 4'd9;
    localparam logic [3:0] C_OFF_DONE   = 4'd10;

    logic        w_hit;
    logic [3:0]  w_off;
    logic [1:0]  w_idx;
    logic        w_err;
    logic        w_wr;
    logic        w_wr_enc;
    logic        w_wr_dec;
    logic [31:0] w_rd;

    logic [31:0] r_enc [4];
    logic [31:0] r_dec [4];
    logic [3:0]  r_enc_mask;
    logic [3:0]  r_dec_mask;
    logic        r_done;
    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_rdata;

    assign w_hit    = data_req_i && (data_addr_i[31:6] == BASE_ADDR[31:6]);
    assign w_off    = data_addr_i[5:2];
    assign w_idx    = data_addr_i[3:2];
    // Misaligned accesses and the unmapped tail of the window both error out.
    assign w_err    = (data_addr_i[1:0] != 2'b00) || (w_off > C_OFF_DONE);
    assign w_wr     = w_hit && data_we_i && !w_err;
    assign w_wr_enc = w_wr && (w_off[3:2] == 2'b00);
    assign w_wr_dec = w_wr && (w_off[3:2] == 2'b01);

    assign data_gnt_o     = w_hit;
    assign data_rvalid_o  = r_rvalid;
    assign data_rdata_o   = r_rdata;
    assign data_err_o     = r_err;
    // The mask only clears on CLEAR/reset, so a full mask is exactly "valid".
    assign enc_valid_o    = &r_enc_mask;
    assign dec_valid_o    = &r_dec_mask;
    assign program_done_o = r_done;

    generate
        for (genvar n = 0; n < 4; n++) begin : g_words
            assign result_enc_o[32*n +: 32] = r_enc[n];
            assign result_dec_o[32*n +: 32] = r_dec[n];
        end
    endgenerate

    // Read data multiplexer for the registered response.
    always_comb begin
        w_rd = 32'd0;
        case (w_off)
            4'd0, 4'd1, 4'd2, 4'd3: w_rd = r_enc[w_idx];
            4'd4, 4'd5, 4'd6, 4'd7: w_rd = r_dec[w_idx];
            C_OFF_STATUS:           w_rd = {29'd0, r_done, dec_valid_o, enc_valid_o};
            default:                w_rd = 32'd0;
        endcase
    end

    // Register file, flags and response pipeline; reset drops any pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < 4; n++) begin
                r_enc[n] <= 32'd0;
                r_dec[n] <= 32'd0;
            end
            r_enc_mask <= 4'd0;
            r_dec_mask <= 4'd0;
            r_done     <= 1'b0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_rvalid <= w_hit;
            r_err    <= w_hit && w_err;
            r_rdata  <= (w_hit && !data_we_i && !w_err) ? w_rd : 32'd0;

            for (int k = 0; k < 4; k++) begin
                if (w_wr_enc && data_be_i[k]) r_enc[w_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
                if (w_wr_dec && data_be_i[k]) r_dec[w_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
            end
            if (w_wr_enc && (data_be_i != 4'd0)) r_enc_mask[w_idx] <= 1'b1;
            if (w_wr_dec && (data_be_i != 4'd0)) r_dec_mask[w_idx] <= 1'b1;

            if (w_wr && (w_off == C_OFF_CLEAR) && data_be_i[0]) begin
                if (data_wdata_i[0]) r_enc_mask <= 4'd0;
                if (data_wdata_i[1]) r_dec_mask <= 4'd0;
            end
            if (w_wr && (w_off == C_OFF_DONE)) r_done <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_result_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_result_mailbox
// Purpose  : Directed self-checking bench for obi_result_mailbox.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_result_mailbox;

    localparam logic [31:0] BASE = 32'h0000_8000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         gnt;
    logic [31:0]  addr = 32'd0;
    logic         we = 1'b0;
    logic [3:0]   be = 4'd0;
    logic [31:0]  wdata = 32'd0;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         err;
    logic [127:0] res_enc;
    logic [127:0] res_dec;
    logic         enc_valid;
    logic         dec_valid;
    logic         done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obi_result_mailbox #(.BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr),
        .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
        .result_enc_o(res_enc), .result_dec_o(res_dec),
        .enc_valid_o(enc_valid), .dec_valid_o(dec_valid),
        .program_done_o(done)
    );

    // One request cycle, then sample the response one cycle later.
    task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, output logic g, output logic rv,
                       output logic [31:0] rd, output logic e);
        @(negedge clk);
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        #1 g = gnt;
        @(negedge clk);
        req = 1'b0; we = 1'b0; be = 4'd0;
        rv = rvalid; rd = rdata; e = err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if ({res_enc, res_dec} !== 256'd0) begin errors++; $display("FAIL reset_results got %h %h exp 0", res_enc, res_dec); end
        checks++; if ({enc_valid, dec_valid, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {enc_valid, dec_valid, done}); end
        rst = 1'b0;
    endtask

    task automatic test_enc_assembly();
        logic g, rv, e; logic [31:0] rd;
        logic [31:0] vals [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        for (int i = 0; i < 4; i++) begin
            bus(BASE + 32'(4*i), 1'b1, 4'hF, vals[i], g, rv, rd, e);
            checks++; if ({g, rv, e, rd} !== {3'b110, 32'd0}) begin errors++; $display("FAIL enc_wr%0d_resp got g=%b rv=%b e=%b rd=%h exp 1 1 0 0", i, g, rv, e, rd); end
            checks++; if (enc_valid !== (i == 3)) begin errors++; $display("FAIL enc_valid_w%0d got %b exp %b", i, enc_valid, (i == 3)); end
        end
        checks++; if (res_enc !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin errors++; $display("FAIL enc_result got %h exp 0f0e0d0c0b0a090807060504_03020100", res_enc); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL enc_dec_valid got %b exp 0", dec_valid); end
    endtask

    task automatic test_partial();
        logic g, rv, e; logic [31:0] rd;
        bus(BASE + 32'h18, 1'b1, 4'b0101, 32'hAABBCCDD, g, rv, rd, e);
        checks++; if (res_dec[95:64] !== 32'h00BB00DD) begin errors++; $display("FAIL partial_word2 got %h exp 00bb00dd", res_dec[95:64]); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL partial_valid0 got %b exp 0", dec_valid); end
        bus(BASE + 32'h10, 1'b1, 4'hF, 32'h11111111, g, rv, rd, e);
        bus(BASE + 32'h14, 1'b1, 4'hF, 32'h22222222, g, rv, rd, e);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL partial_valid3of4 got %b exp 0", dec_valid); end
        bus(BASE + 32'h1C, 1'b1, 4'hF, 32'h44444444, g, rv, rd, e);
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL partial_valid got %b exp 1", dec_valid); end
        checks++; if (res_dec !== 128'h44444444_00BB00DD_22222222_11111111) begin errors++; $display("FAIL partial_result got %h", res_dec); end
        bus(BASE + 32'h20, 1'b0, 4'hF, 32'd0, g, rv, rd, e);
        checks++; if ({rv, e, rd} !== {2'b10, 32'h3}) begin errors++; $display("FAIL partial_status got rv=%b e=%b rd=%h exp 1 0 3", rv, e, rd); end
        bus(BASE + 32'h18, 1'b0, 4'hF, 32'd0, g, rv, rd, e);
        checks++; if (rd !== 32'h00BB00DD) begin errors++; $display("FAIL partial_readback got %h exp 00bb00dd", rd); end
    endtask

    task automatic test_clear();
        logic g, rv, e; logic [31:0] rd;
        bus(BASE + 32'h24, 1'b1, 4'hF, 32'h1, g, rv, rd, e);
        checks++; if ({enc_valid, dec_valid} !== 2'b01) begin errors++; $display("FAIL clear_valids got %b exp 01", {enc_valid, dec_valid}); end
        checks++; if (res_enc !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin errors++; $display("FAIL clear_data got %h", res_enc); end
        bus(BASE + 32'h24, 1'b0, 4'hF, 32'd0, g, rv, rd, e);
        checks++; if ({rv, e, rd} !== {2'b10, 32'd0}) begin errors++; $display("FAIL clear_read got rv=%b e=%b rd=%h exp 1 0 0", rv, e, rd); end
        bus(BASE + 32'h0C, 1'b1, 4'hF, 32'hDEADBEEF, g, rv, rd, e);
        checks++; if (enc_valid !== 1'b0) begin errors++; $display("FAIL clear_revalid got %b exp 0", enc_valid); end
        checks++; if (res_enc[127:96] !== 32'hDEADBEEF) begin errors++; $display("FAIL clear_word3 got %h exp deadbeef", res_enc[127:96]); end
        bus(BASE + 32'h00, 1'b1, 4'h0, 32'h12345678, g, rv, rd, e);
        checks++; if ({rv, e, res_enc[31:0]} !== {2'b10, 32'h03020100}) begin errors++; $display("FAIL be0_write got rv=%b e=%b w0=%h exp 1 0 03020100", rv, e, res_enc[31:0]); end
    endtask

    task automatic test_errors();
        logic g, rv, e; logic [31:0] rd;
        logic [127:0] enc_before;
        enc_before = res_enc;
        bus(BASE + 32'h30, 1'b0, 4'hF, 32'd0, g, rv, rd, e);
        checks++; if ({g, rv, e, rd} !== {3'b111, 32'd0}) begin errors++; $display("FAIL err_unmapped got g=%b rv=%b e=%b rd=%h exp 1 1 1 0", g, rv, e, rd); end
        bus(BASE + 32'h02, 1'b1, 4'hF, 32'hFFFFFFFF, g, rv, rd, e);
        checks++; if ({g, rv, e, rd} !== {3'b111, 32'd0}) begin errors++; $display("FAIL err_misaligned got g=%b rv=%b e=%b rd=%h exp 1 1 1 0", g, rv, e, rd); end
        checks++; if (res_enc !== enc_before) begin errors++; $display("FAIL err_nochange got %h exp %h", res_enc, enc_before); end
        bus(BASE + 32'h40, 1'b0, 4'hF, 32'd0, g, rv, rd, e);
        checks++; if ({g, rv} !== 2'b00) begin errors++; $display("FAIL miss_window got g=%b rv=%b exp 0 0", g, rv); end
        bus(BASE + 32'h20, 1'b1, 4'hF, 32'hFFFFFFFF, g, rv, rd, e);
        checks++; if ({rv, e} !== 2'b10) begin errors++; $display("FAIL status_write got rv=%b e=%b exp 1 0", rv, e); end
        bus(BASE + 32'h20, 1'b0, 4'hF, 32'd0, g, rv, rd, e);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL status_after_write got %h exp 2", rd); end
    endtask

    task automatic test_back_to_back();
        logic g, rv, e; logic [31:0] rd;
        logic [31:0] status_rd;
        int rv_cnt;
        bus(BASE + 32'h24, 1'b1, 4'hF, 32'h3, g, rv, rd, e);
        checks++; if ({enc_valid, dec_valid} !== 2'b00) begin errors++; $display("FAIL clear_both got %b exp 00", {enc_valid, dec_valid}); end
        rv_cnt = 0; status_rd = 32'hX;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0 && rvalid === 1'b1) rv_cnt++;
            if (i == 5) status_rd = rdata;
            if (i < 4) begin
                req = 1'b1; addr = BASE + 32'(4*i); we = 1'b1; be = 4'hF; wdata = 32'hA0A0A0A0 + 32'(i);
            end else if (i == 4) begin
                req = 1'b1; addr = BASE + 32'h20; we = 1'b0;
            end else if (i == 5) begin
                req = 1'b1; addr = BASE + 32'h28; we = 1'b1; wdata = 32'd0;
            end else begin
                req = 1'b0; we = 1'b0; be = 4'd0;
            end
        end
        checks++; if (rv_cnt !== 6) begin errors++; $display("FAIL b2b_rvalid_cycles got %0d exp 6", rv_cnt); end
        checks++; if (status_rd !== 32'h1) begin errors++; $display("FAIL b2b_status got %h exp 1", status_rd); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", done); end
        checks++; if (res_enc !== 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0) begin errors++; $display("FAIL b2b_result got %h", res_enc); end
        @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", rvalid); end
    endtask

    task automatic test_reset_mid();
        logic g, rv, e; logic [31:0] rd;
        bus(BASE + 32'h00, 1'b1, 4'hF, 32'hA5A5A5A5, g, rv, rd, e);
        bus(BASE + 32'h04, 1'b1, 4'hF, 32'h5A5A5A5A, g, rv, rd, e);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({res_enc, done, enc_valid} !== {128'd0, 2'b00}) begin errors++; $display("FAIL rst_mid_clear got %h done=%b v=%b exp 0", res_enc, done, enc_valid); end
        bus(BASE + 32'h08, 1'b1, 4'hF, 32'h33333333, g, rv, rd, e);
        bus(BASE + 32'h0C, 1'b1, 4'hF, 32'h44444444, g, rv, rd, e);
        checks++; if (enc_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", enc_valid); end
        bus(BASE + 32'h00, 1'b0, 4'hF, 32'd0, g, rv, rd, e);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_mid_word0 got %h exp 0", rd); end
        bus(BASE + 32'h04, 1'b0, 4'hF, 32'd0, g, rv, rd, e);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_mid_word1 got %h exp 0", rd); end
    endtask

    initial begin
        test_reset();
        test_enc_assembly();
        test_partial();
        test_clear();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obi_result_mailbox.md
# obi_result_mailbox

OBI data-bus slave that collects the 128-bit AES encryption and decryption results written by the firmware running on `cv32e40x_core_with_aes`. It sits downstream of the core's data port, in parallel with the data memory, and decodes a 64-byte address window. It assembles each result from four word writes, flags when each result is complete, and drives the `result_enc`/`result_dec` and completion signals consumed by the testbench interface. It also provides status readback and a clear mechanism to the firmware.

## Interface

Parameters:
- `BASE_ADDR`, default `32'h0000_8000`: byte address of the window; must be 64-byte aligned.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `data_req_i` in 1: OBI request.
- `data_gnt_o` out 1: OBI grant.
- `data_addr_i` in 32: byte address.
- `data_we_i` in 1: 1 = write, 0 = read.
- `data_be_i` in 4: byte enables.
- `data_wdata_i` in 32: write data.
- `data_rvalid_o` out 1: response valid.
- `data_rdata_o` out 32: read data.
- `data_err_o` out 1: response error; qualified by `data_rvalid_o`.
- `result_enc_o` out 128: assembled encryption result.
- `result_dec_o` out 128: assembled decryption result.
- `enc_valid_o` out 1: all four encryption words written since the last clear.
- `dec_valid_o` out 1: all four decryption words written since the last clear.
- `program_done_o` out 1: sticky flag, set by firmware.

## Operation

Window decode:
- `hit = data_req_i && (data_addr_i[31:6] == BASE_ADDR[31:6])`.
- Requests that do not hit are ignored entirely: no grant and no response.

Register map (byte offset within the window):
- 0x00–0x0C: ENC word 0..3. Word *n* maps to `result_enc_o[32n+31:32n]`. Read/write.
- 0x10–0x1C: DEC word 0..3, with the same mapping onto `result_dec_o`. Read/write.
- 0x20 STATUS, read-only: bit0 = enc_valid, bit1 = dec_valid, bit2 = program_done; other bits read 0. Writes are ignored with no error.
- 0x24 CLEAR, write-only: bit0 clears enc_valid and the enc written mask; bit1 does the same for dec. Data registers are untouched. Reads return 0.
- 0x28 DONE, write-only: any write sets program_done. Reads return 0.
- 0x2C–0x3C: unmapped. Response is `data_err_o = 1`, rdata 0, no state change.
- Any address with `data_addr_i[1:0] != 0`: `data_err_o = 1`, no state change.

Writes to the data words:
- Only bytes with `data_be_i[k] = 1` are updated.
- Each result keeps a 4-bit written mask. A granted write with any byte enable set marks its word as written.
- A write with `be = 0` completes with no error and no effect.
- `enc_valid`/`dec_valid` is set when the mask becomes `4'b1111`. It stays set until CLEAR or reset.
- Rewriting a word while valid updates the data and leaves valid set.
- CLEAR bit0 and bit1 may be written together; each bit acts independently.
- `program_done` clears only on reset.

## Timing

- `data_gnt_o = hit`, combinational. The block is always ready and never stalls.
- Response phase: `data_rvalid_o`, `data_rdata_o` and `data_err_o` are registered and valid exactly 1 cycle after the grant.
- Back-to-back grants are accepted every cycle, so `data_rvalid_o` may stay high continuously. Responses are in order, one per grant.
- Write state is updated at the clock edge that ends the grant cycle:
  - the new data and written mask are visible at the outputs and to a read granted in the next cycle;
  - `enc_valid_o`/`dec_valid_o` rises in the cycle after the completing write's grant, i.e. the same cycle as that write's `data_rvalid_o`.
- A read granted in the same cycle as the completing write cannot occur, because the bus is single-port.
- `data_rdata_o` is 0 for write responses and error responses.
- Reset (`rst_i` high at a clock edge) forces the following at the next edge: all data registers, masks and flags to 0; `data_rvalid_o = 0`; `data_err_o = 0`; `data_rdata_o = 0`; `result_*_o = 0`; `*_valid_o = 0`; `program_done_o = 0`.
  - A response pending from the cycle before reset is dropped.
  - `data_gnt_o` may assert during reset, but granted transactions have no effect.

## Test plan

1. **Encryption result assembly.** Reset, then write ENC words 0..3 with 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, all `be = 4'hF`. Required:
   - `result_enc_o = 128'h0F0E0D0C_0B0A0908_07060504_03020100`;
   - `enc_valid_o` rises the cycle after the 4th grant;
   - `dec_valid_o` stays 0.
2. **Partial writes and byte enables.** Write DEC word 2 = 0xAABBCCDD with `be = 4'b0101`. Required: word 2 = 0x00BB00DD, `dec_valid_o = 0`. Then write words 0, 1 and 3; required: `dec_valid_o = 1`. Then read STATUS; required: rdata = 0x2 (3 if case 1 has already run).
3. **CLEAR, then re-assembly.** After case 1, write CLEAR = 0x1. Required:
   - `enc_valid_o = 0` next cycle;
   - `result_enc_o` unchanged.
   Then write only ENC word 3; required: valid stays 0.
4. **Error responses.** Read offset 0x30 and write address BASE+0x02. Required for both: rvalid one cycle after grant, `err = 1`, rdata 0, no state change. A request to BASE+0x40 gets no grant.
5. **Back-to-back throughput and DONE.** Issue 6 consecutive grants (4 ENC writes, a STATUS read, a DONE write). Required:
   - rvalid high for 6 consecutive cycles;
   - the STATUS read returns 0x1;
   - `program_done_o = 1` after the last response.
6. **Reset mid-operation.** Write 2 ENC words, assert `rst_i` for 1 cycle, then write words 2 and 3. Required: `enc_valid_o = 0`, and words 0–1 read back as 0.
